// File: rtl/mcbsp_master_tx_gen.sv
// mcbsp_master_tx_gen
// McBSP-style master transmit generator. Produces a continuous bit clock
// (clkr), a one-bit-period frame sync (fsr) ahead of every word, and serial
// data (miso) MSB first. Words come in through a one-word holding register
// with a valid/ready handshake. The frame request arrives from another clock
// domain and is synchronized before edge detection.
//
// Optional feature: define MCBSP_TX_DEBUG_EN to build the debug bus and the
// wrapping frame counter. Without it, debug_out is tied to zero.

module mcbsp_master_tx_gen #(
  parameter int DATA_W  = 32,  // max word width, 8..32
  parameter int NUM_W   = 9,   // width of words-per-frame count
  parameter int CLK_DIV = 2    // clk cycles per serial bit period, even, >= 2
) (
  input  logic              mcbsp_clk_in,
  input  logic              mcbsp_rst_in,
  input  logic              start_in,
  input  logic [5:0]        cfg_word_len,
  input  logic [NUM_W-1:0]  cfg_word_num,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              mcbsp_master_clkr,
  output logic              mcbsp_master_fsr,
  output logic              mcbsp_master_miso,
  output logic              word_upd,
  output logic              frame_done,
  output logic              busy,
  output logic              underrun,
  output logic              overlap_err,
  input  logic              err_clr,
  output logic [31:0]       debug_out
);

  localparam int              CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
  localparam logic [5:0]       LEN_MAX  = 6'(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_FSYNC = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  // Synchronizer and bit-period timing
  logic [2:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;     // phase of the cycle presented after the next edge
  logic             r_clkr;

  // FSM and serial outputs
  state_t           r_state;
  logic [5:0]       r_len;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] r_word_cnt;  // words completed in the current frame
  logic [5:0]       r_bit_cnt;   // data bits driven for the current word
  logic [DATA_W-1:0] r_shift;
  logic             r_fsr;
  logic             r_miso;
  logic             r_word_upd;
  logic             r_frame_done;
  logic             r_busy;

  // Holding register and sticky status
  logic [DATA_W-1:0] r_hold;
  logic             r_hold_full;
  logic             r_underrun;
  logic             r_overlap_err;

  // Decoded events
  logic             w_start_edge;
  logic             w_per_start;
  logic             w_per_last;
  logic [5:0]       w_len_clamped;
  logic             w_launch;
  logic             w_word_end;
  logic             w_more_words;
  logic             w_fsync_entry;
  logic             w_upd_set;
  logic             w_done_set;
  logic             w_hold_wr;
  logic             w_underrun_set;
  logic             w_overlap_set;
  logic [DATA_W-1:0] w_load_word;

  // An edge of the cross-domain request is taken only from the two
  // metastability-settled stages.
  assign w_start_edge = (r_sync[2:1] == 2'b01);

  // r_cnt names the phase of the cycle about to be presented, so an edge
  // with r_cnt == 0 launches a new bit period and one with r_cnt == CNT_LAST
  // launches that period's final cycle.
  assign w_per_start = (r_cnt == '0);
  assign w_per_last  = (r_cnt == CNT_LAST);

  assign w_len_clamped = ((cfg_word_len == 6'd0) || (cfg_word_len > LEN_MAX))
                         ? LEN_MAX : cfg_word_len;

  assign w_launch      = (r_state == ST_IDLE) && w_start_edge && (cfg_word_num != '0);
  assign w_word_end    = (r_state == ST_SHIFT) && (r_bit_cnt == r_len);
  assign w_more_words  = (r_word_cnt != r_num);
  assign w_fsync_entry = w_per_start &&
                         ((r_state == ST_ARM) || (w_word_end && w_more_words));
  assign w_upd_set     = w_word_end && w_per_last;
  assign w_done_set    = w_upd_set && ((r_word_cnt + NUM_W'(1)) == r_num);

  assign w_hold_wr      = din_valid && !r_hold_full;
  assign w_underrun_set = w_fsync_entry && !r_hold_full;
  assign w_overlap_set  = w_start_edge && (r_state != ST_IDLE);

  // Word left-justified into the shift register; an empty holding register
  // sends zeros. Bits above len-1 fall off the top.
  assign w_load_word = r_hold_full ? (r_hold << (LEN_MAX - r_len)) : '0;

  // Three-flop synchronizer for the frame request.
  always_ff @(posedge mcbsp_clk_in or posedge mcbsp_rst_in) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (mcbsp_rst_in) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], start_in};
    end
  end

  // Free-running bit-period counter and bit clock (high for the first half).
  always_ff @(posedge mcbsp_clk_in or posedge mcbsp_rst_in) begin
    if (mcbsp_rst_in) begin
      r_cnt  <= '0;
      r_clkr <= 1'b0;
    end else begin
      r_clkr <= (r_cnt < CNT_HALF);
      r_cnt  <= w_per_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Frame FSM with registered serial outputs and pulses.
  always_ff @(posedge mcbsp_clk_in or posedge mcbsp_rst_in) begin
    if (mcbsp_rst_in) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_num        <= '0;
      r_word_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_fsr        <= 1'b0;
      r_miso       <= 1'b0;
      r_word_upd   <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_word_upd   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state    <= ST_ARM;
            r_len      <= w_len_clamped;
            r_num      <= cfg_word_num;
            r_word_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_ARM: begin
          if (w_per_start) begin
            r_state   <= ST_FSYNC;
            r_fsr     <= 1'b1;
            r_miso    <= 1'b0;
            r_shift   <= w_load_word;
            r_bit_cnt <= '0;
          end
        end
        ST_FSYNC: begin
          if (w_per_start) begin
            r_state   <= ST_SHIFT;
            r_fsr     <= 1'b0;
            r_miso    <= r_shift[DATA_W-1];
            r_shift   <= r_shift << 1;
            r_bit_cnt <= 6'd1;
          end
        end
        ST_SHIFT: begin
          if (w_upd_set) begin
            // Final cycle of the word's last bit period.
            r_word_upd   <= 1'b1;
            r_frame_done <= w_done_set;
            r_word_cnt   <= r_word_cnt + NUM_W'(1);
          end else if (w_per_start) begin
            if (w_word_end) begin
              if (w_more_words) begin
                r_state   <= ST_FSYNC;
                r_fsr     <= 1'b1;
                r_miso    <= 1'b0;
                r_shift   <= w_load_word;
                r_bit_cnt <= '0;
              end else begin
                r_state <= ST_IDLE;
                r_fsr   <= 1'b0;
                r_miso  <= 1'b0;
                r_busy  <= 1'b0;
              end
            end else begin
              r_miso    <= r_shift[DATA_W-1];
              r_shift   <= r_shift << 1;
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // One-word holding register: emptied on FSYNC entry, refilled by handshake.
  always_ff @(posedge mcbsp_clk_in or posedge mcbsp_rst_in) begin
    // NOTE: only the full flag needs reset for correctness; the data word is
    // reset as well so the debug/serial path never shows stale X after reset.
    if (mcbsp_rst_in) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_fsync_entry) begin
        r_hold_full <= w_hold_wr;
      end else if (w_hold_wr) begin
        r_hold_full <= 1'b1;
      end
      if (w_hold_wr) begin
        r_hold <= din;
      end
    end
  end

  // Sticky error flags; a set event wins over a clear in the same cycle.
  always_ff @(posedge mcbsp_clk_in or posedge mcbsp_rst_in) begin
    if (mcbsp_rst_in) begin
      r_underrun    <= 1'b0;
      r_overlap_err <= 1'b0;
    end else begin
      if (w_underrun_set)    r_underrun <= 1'b1;
      else if (err_clr)      r_underrun <= 1'b0;
      if (w_overlap_set)     r_overlap_err <= 1'b1;
      else if (err_clr)      r_overlap_err <= 1'b0;
    end
  end

  assign din_ready         = !r_hold_full;
  assign mcbsp_master_clkr = r_clkr;
  assign mcbsp_master_fsr  = r_fsr;
  assign mcbsp_master_miso = r_miso;
  assign word_upd          = r_word_upd;
  assign frame_done        = r_frame_done;
  assign busy              = r_busy;
  assign underrun          = r_underrun;
  assign overlap_err       = r_overlap_err;

`ifdef MCBSP_TX_DEBUG_EN
  logic [15:0] r_frames_sent;
  logic [9:0]  w_word_cnt10;

  if (NUM_W >= 10) begin : g_wc_trunc
    assign w_word_cnt10 = r_word_cnt[9:0];
  end else begin : g_wc_pad
    assign w_word_cnt10 = {{(10-NUM_W){1'b0}}, r_word_cnt};
  end

  // Wrapping count of completed frames.
  always_ff @(posedge mcbsp_clk_in or posedge mcbsp_rst_in) begin
    if (mcbsp_rst_in) begin
      r_frames_sent <= '0;
    end else if (w_done_set) begin
      r_frames_sent <= r_frames_sent + 16'd1;
    end
  end

  assign debug_out = {r_state, r_underrun, r_overlap_err, 2'b00,
                      w_word_cnt10, r_frames_sent};
`else
  assign debug_out = '0;
`endif

endmodule

// File: tb/tb_mcbsp_master_tx_gen.sv
// Self-checking bench for mcbsp_master_tx_gen. A reference model builds the
// expected serial stream of each frame as a list of (fsr, miso) bit periods
// from the word length, word count and supplied words; a monitor captures the
// DUT stream on each clkr falling edge and counts pulses.

module tb_mcbsp_master_tx_gen;

  localparam int DATA_W  = 32;
  localparam int NUM_W   = 9;
  localparam int CLK_DIV = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_in = 1'b0;
  logic [5:0]        cfg_word_len = '0;
  logic [NUM_W-1:0]  cfg_word_num = '0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic              clkr, fsr, miso;
  logic              word_upd, frame_done, busy, underrun, overlap_err;
  logic              err_clr = 1'b0;
  logic [31:0]       debug_out;

  mcbsp_master_tx_gen #(
    .DATA_W (DATA_W),
    .NUM_W  (NUM_W),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .mcbsp_clk_in     (clk),
    .mcbsp_rst_in     (rst),
    .start_in         (start_in),
    .cfg_word_len     (cfg_word_len),
    .cfg_word_num     (cfg_word_num),
    .din              (din),
    .din_valid        (din_valid),
    .din_ready        (din_ready),
    .mcbsp_master_clkr(clkr),
    .mcbsp_master_fsr (fsr),
    .mcbsp_master_miso(miso),
    .word_upd         (word_upd),
    .frame_done       (frame_done),
    .busy             (busy),
    .underrun         (underrun),
    .overlap_err      (overlap_err),
    .err_clr          (err_clr),
    .debug_out        (debug_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [1:0] bits_q[$];
  int  n_upd, n_done, done_wo_upd, stray, busy_cyc;
  bit  capturing, prev_clkr, after_done, busy_after;

  always @(negedge clk) begin
    if (rst) begin
      prev_clkr  = 1'b0;
      capturing  = 1'b0;
      after_done = 1'b0;
    end else begin
      if (after_done) begin
        busy_after = busy;
        after_done = 1'b0;
      end
      if (prev_clkr && !clkr) begin
        if (fsr && busy) capturing = 1'b1;
        if (capturing) bits_q.push_back({fsr, miso});
        else if (fsr || miso) stray++;
      end
      if (busy) busy_cyc++;
      if (word_upd) n_upd++;
      if (frame_done) begin
        n_done++;
        if (!word_upd) done_wo_upd++;
        capturing  = 1'b0;
        after_done = 1'b1;
      end
      prev_clkr = clkr;
    end
  end

  task automatic clear_mon();
    bits_q.delete();
    n_upd = 0; n_done = 0; done_wo_upd = 0; stray = 0; busy_cyc = 0;
    capturing = 1'b0; after_done = 1'b0; busy_after = 1'b1;
  endtask

  // ---------------- one frame against the model ----------------
  task automatic run_frame(input string name, input int len_cfg, input int num,
                           input int k, input bit overlap);
    int                L;
    int                idx;
    int                budget;
    int                first;
    bit                done_seen;
    bit                exp_under;
    logic [DATA_W-1:0] w[$];
    logic [1:0]        exp_q[$];
    logic [DATA_W-1:0] cur;

    L = (len_cfg == 0 || len_cfg > DATA_W) ? DATA_W : len_cfg;
    exp_under = (k < num);
    for (int i = 0; i < num; i++) w.push_back($urandom);
    for (int i = 0; i < num; i++) begin
      cur = (i < k) ? w[i] : '0;
      exp_q.push_back(2'b10);
      for (int b = L - 1; b >= 0; b--) exp_q.push_back({1'b0, cur[b]});
    end

    @(posedge clk);
    clear_mon();
    cfg_word_len = 6'(len_cfg);
    cfg_word_num = NUM_W'(num);
    idx = 0;
    done_seen = 1'b0;
    budget = num * (L + 1) * CLK_DIV + 80;
    for (int c = 0; c < budget && !done_seen; c++) begin
      @(negedge clk);
      if (idx < k) begin
        din_valid = 1'b1;
        din = w[idx];
        if (din_ready) idx++;
      end else begin
        din_valid = 1'b0;
      end
      err_clr = (c == 1);
      if (c == 4) start_in = 1'b1;
      if (c == 12) start_in = 1'b0;
      if (overlap && c == 40) start_in = 1'b1;
      if (overlap && c == 48) start_in = 1'b0;
      if (n_done > 0) done_seen = 1'b1;
    end
    din_valid = 1'b0;
    start_in  = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk);

    check({name, "_done_in_time"}, done_seen, 1);
    check({name, "_word_upd_cnt"}, n_upd, num);
    check({name, "_frame_done_cnt"}, n_done, 1);
    check({name, "_done_without_upd"}, done_wo_upd, 0);
    check({name, "_bit_periods"}, bits_q.size(), exp_q.size());
    first = -1;
    for (int i = 0; i < bits_q.size() && i < exp_q.size(); i++)
      if (bits_q[i] !== exp_q[i] && first < 0) first = i;
    check({name, "_first_bad_bit"}, first, -1);
    check({name, "_underrun"}, underrun, exp_under);
    check({name, "_overlap_err"}, overlap_err, overlap);
    check({name, "_busy_after_done"}, busy_after, 0);
    check({name, "_stray_serial"}, stray, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic zero_num_test();
    @(posedge clk);
    clear_mon();
    cfg_word_len = 6'd8;
    cfg_word_num = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      start_in = (c >= 4 && c < 12);
    end
    check("num0_busy_cycles", busy_cyc, 0);
    check("num0_pulses", n_upd + n_done, 0);
    check("num0_serial", stray, 0);
    check("num0_flags", {underrun, overlap_err}, 2'b00);
  endtask

  task automatic reset_test();
    logic [DATA_W-1:0] w0;
    int idx;
    bit reached;
    @(posedge clk);
    clear_mon();
    cfg_word_len = 6'd8;
    cfg_word_num = NUM_W'(4);
    idx = 0;
    reached = 1'b0;
    w0 = $urandom;
    for (int c = 0; c < 400 && !reached; c++) begin
      @(negedge clk);
      if (idx < 4) begin
        din_valid = 1'b1;
        din = w0 + DATA_W'(idx);
        if (din_ready) idx++;
      end else din_valid = 1'b0;
      start_in = (c >= 4 && c < 12);
      if (n_upd >= 1) reached = 1'b1;
    end
    check("rst_reached_word2", reached, 1);
    // Mid-way into word 2
    repeat (6) @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    start_in = 1'b0;
    @(negedge clk);
    check("rst_outputs_zero",
          {clkr, fsr, miso, word_upd, frame_done, busy, underrun, overlap_err}, 8'h00);
    check("rst_din_ready", din_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_clkr_restarts_high", clkr, 1);
    repeat (60) @(negedge clk);
    check("rst_no_frame_done", n_done, 0);
    check("rst_idle_after", busy, 0);
  endtask

  initial begin
    int len_cfg, num, k, pick;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset_serial", {clkr, fsr, miso}, 3'b000);
    check("reset_status", {word_upd, frame_done, busy, underrun, overlap_err}, 5'b0);
    check("reset_din_ready", din_ready, 1);
`ifndef MCBSP_TX_DEBUG_EN
    check("reset_debug_zero", debug_out, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("clkr_high_after_release", clkr, 1);

    run_frame("len32_num1", 32, 1, 1, 1'b0);
    run_frame("len8_num3", 8, 3, 3, 1'b0);
    run_frame("len16_underrun", 16, 2, 1, 1'b0);
    repeat (20) @(negedge clk);
    check("underrun_sticky", underrun, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check("underrun_cleared", underrun, 0);

    run_frame("overlap_len32_num4", 32, 4, 4, 1'b1);
    run_frame("len0_clamp", 0, 1, 1, 1'b0);
    run_frame("len40_clamp", 40, 1, 1, 1'b0);
    zero_num_test();

    reset_test();
    run_frame("after_reset", 8, 2, 2, 1'b0);

    for (int t = 0; t < 8; t++) begin
      pick = $urandom_range(0, 4);
      case (pick)
        0:       len_cfg = 0;
        1:       len_cfg = $urandom_range(33, 63);
        2:       len_cfg = 32;
        default: len_cfg = $urandom_range(1, 32);
      endcase
      num = $urandom_range(1, 4);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, num - 1) : num;
      run_frame($sformatf("rand%0d", t), len_cfg, num, k, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
